// File: rtl/mem_axi_dpram_pkg.sv
// Shared definitions for the byte-lane dual-port RAM with read pipeline.
package mem_axi_dpram_pkg;

    // Supported read latencies; anything else is clamped into this range.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Clear engine states: CLEAR zeroes the array, READY serves requests.
    typedef enum logic [0:0] {
        StClear = 1'b0,
        StReady = 1'b1
    } clr_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Map a requested read latency onto a supported one.
    function automatic int rd_lat_sel(input int lat);
        return (lat >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
    endfunction

endpackage

// File: rtl/mem_axi_dpram_pipe_lane.sv
// One 8-bit byte lane: simple dual-port array, write port plus synchronous read
// port whose address is taken straight from the inputs.
module mem_axi_dpram_pipe_lane #(
    parameter int DEPTH_AW = 8
) (
    input  logic                i_clk,
    input  logic                i_wen,
    input  logic [DEPTH_AW-1:0] i_waddr,
    input  logic [7:0]          i_wdata,
    input  logic                i_ren,
    input  logic [DEPTH_AW-1:0] i_raddr,
    output logic [7:0]          o_rdata
);

    localparam int DEPTH = 1 << DEPTH_AW;

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Array write port; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port returns pre-write data on a same-edge collision; output holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_ren) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_axi_dpram_pipe.sv
// Byte-lane dual-port RAM with write-collision merge, 1- or 2-cycle read pipeline
// and a clear engine that zeroes the array after reset.
module mem_axi_dpram_pipe
    import mem_axi_dpram_pkg::*;
#(
    parameter int WIDTH_AD       = 10,
    parameter int WIDTH_DA       = 32,
    parameter int WIDTH_DS       = WIDTH_DA / 8,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [WIDTH_AD-1:0] WADDR,
    input  logic [WIDTH_DA-1:0] WDATA,
    input  logic [WIDTH_DS-1:0] WSTRB,
    input  logic                WEN,
    input  logic [WIDTH_AD-1:0] RADDR,
    input  logic [WIDTH_DS-1:0] RSTRB,
    input  logic                REN,
    output logic [WIDTH_DA-1:0] RDATA,
    output logic                RVALID,
    output logic                BUSY
);

    localparam int WIDTH_DSB = clog2(WIDTH_DS);
    localparam int AW        = WIDTH_AD - WIDTH_DSB;
    localparam int LAT       = rd_lat_sel(RD_LAT);

    localparam logic [AW-1:0] CNT_LAST = '1;

    clr_state_e          r_state;
    logic [AW-1:0]       r_clr_cnt;

    logic                w_busy;
    logic                w_clr_wen;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [AW-1:0]       w_widx;
    logic [AW-1:0]       w_ridx;
    logic [WIDTH_DS-1:0] w_coll;
    logic [WIDTH_DS-1:0] w_lane_wen;
    logic [AW-1:0]       w_lane_waddr;
    logic [WIDTH_DA-1:0] w_lane_wdata;
    logic [WIDTH_DA-1:0] w_lane_rdata;
    logic [WIDTH_DA-1:0] w_s1_data;

    logic                r_s1_valid;
    logic [WIDTH_DS-1:0] r_s1_rstrb;
    logic [WIDTH_DS-1:0] r_s1_coll;
    logic [WIDTH_DA-1:0] r_s1_wdata;

    // Byte-offset address bits select nothing inside a word.
    logic w_unused_addr;
    assign w_unused_addr = ^{WADDR, RADDR};

    assign w_busy = (r_state == StClear);
    assign BUSY   = w_busy;

    // Nothing touches the array or the pipeline while reset is held.
    assign w_clr_wen = w_busy & ~RESET;
    assign w_wr_acc  = WEN & ~w_busy & ~RESET;
    assign w_rd_acc  = REN & ~w_busy & ~RESET;

    assign w_widx = WADDR[WIDTH_AD-1:WIDTH_DSB];
    assign w_ridx = RADDR[WIDTH_AD-1:WIDTH_DSB];

    // Lanes written by the accepted write that land on the word being read.
    assign w_coll = (w_wr_acc && (w_widx == w_ridx)) ? WSTRB : '0;

    // Lane write port: the clear engine owns it while busy.
    always_comb begin
        w_lane_wen   = '0;
        w_lane_waddr = w_widx;
        w_lane_wdata = WDATA;
        if (w_clr_wen) begin
            w_lane_wen   = '1;
            w_lane_waddr = r_clr_cnt;
            w_lane_wdata = '0;
        end else if (w_wr_acc) begin
            w_lane_wen   = WSTRB;
        end
    end

    for (genvar b = 0; b < WIDTH_DS; b++) begin : g_lane
        mem_axi_dpram_pipe_lane #(
            .DEPTH_AW (AW)
        ) u_lane (
            .i_clk   (CLK),
            .i_wen   (w_lane_wen[b]),
            .i_waddr (w_lane_waddr),
            .i_wdata (w_lane_wdata[8*b +: 8]),
            .i_ren   (w_rd_acc),
            .i_raddr (w_ridx),
            .o_rdata (w_lane_rdata[8*b +: 8])
        );
    end

    // Clear FSM: sweep every word once, then serve requests.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                StClear: begin
                    r_clr_cnt <= r_clr_cnt + AW'(1);
                    if (r_clr_cnt == CNT_LAST) begin
                        r_state <= StReady;
                    end
                end
                StReady: begin
                    r_state <= StReady;
                end
                default: begin
                    r_state <= StReady;
                end
            endcase
        end
    end

    // First read stage: remember strobes and collision bytes alongside the array read.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_rstrb <= '0;
            r_s1_coll  <= '0;
            r_s1_wdata <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_rstrb <= RSTRB;
                r_s1_coll  <= w_coll;
                r_s1_wdata <= WDATA;
            end
        end
    end

    // Per-lane merge; built only from registers so it holds between reads.
    always_comb begin
        w_s1_data = '0;
        for (int b = 0; b < WIDTH_DS; b++) begin
            if (r_s1_rstrb[b]) begin
                w_s1_data[8*b +: 8] = r_s1_coll[b] ? r_s1_wdata[8*b +: 8]
                                                   : w_lane_rdata[8*b +: 8];
            end
        end
    end

    if (LAT == 2) begin : g_lat2
        logic                r_s2_valid;
        logic [WIDTH_DA-1:0] r_rdata;

        // Second stage captures merged data only when a read completes.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_s2_valid <= 1'b0;
                r_rdata    <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rdata <= w_s1_data;
                end
            end
        end

        assign RDATA  = r_rdata;
        assign RVALID = r_s2_valid;
    end else begin : g_lat1
        assign RDATA  = w_s1_data;
        assign RVALID = r_s1_valid;
    end

endmodule

// File: doc/mem_axi_dpram_pipe.md
MEM_AXI_DPRAM_PIPE -- requirements
Module: mem_axi_dpram_pipe

Interface
REQ-001 SHALL have parameter WIDTH_AD, default 10: memory size in bytes = 1<<WIDTH_AD.
REQ-002 SHALL have parameter WIDTH_DA, default 32: data width in bits; legal values 8, 16, 32, 64, 128.
REQ-003 SHALL have parameter WIDTH_DS, default WIDTH_DA/8: number of byte lanes; WIDTH_DSB = clog2(WIDTH_DS).
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 and 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: when 1, zero the whole array after reset.
REQ-006 SHALL have port CLK  input  1  sole clock; all logic samples on its rising edge.
REQ-007 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-008 SHALL have port WADDR  input  WIDTH_AD  write byte address; word index = WADDR[WIDTH_AD-1:WIDTH_DSB], low bits ignored.
REQ-009 SHALL have ports WDATA  input  WIDTH_DA and WSTRB  input  WIDTH_DS: write data and per-byte write enables.
REQ-010 SHALL have port WEN  input  1  write request.
REQ-011 SHALL have port RADDR  input  WIDTH_AD  read byte address, decoded like WADDR.
REQ-012 SHALL have ports RSTRB  input  WIDTH_DS and REN  input  1: per-byte read enables and read request.
REQ-013 SHALL have port RDATA  output  WIDTH_DA  registered read data.
REQ-014 SHALL have port RVALID  output  1  high for exactly one cycle when RDATA carries a completed read.
REQ-015 SHALL have port BUSY  output  1  high while the clear engine runs; requests are not accepted.

Function
REQ-016 SHALL write byte lane b of word WADDR with WDATA[8b+7:8b] at the clock edge where WEN=1, WSTRB[b]=1 and BUSY=0.
REQ-017 SHALL accept a read when REN=1 and BUSY=0; RVALID and RDATA SHALL appear RD_LAT cycles later.
REQ-018 SHALL accept one read and one write per cycle with no stalls; back-to-back reads SHALL give back-to-back RVALID pulses.
REQ-019 SHALL return 0 in lane b of RDATA when RSTRB[b]=0 for that read.
REQ-020 SHALL resolve a same-cycle read and write to the same word per lane: lanes with WSTRB=1 return the new WDATA byte; other lanes return stored data.
REQ-021 SHALL, with RD_LAT=2, sample array data in the first stage; a write in the cycle after the read SHALL NOT alter the returned data.
REQ-022 SHALL hold RDATA at its last value while RVALID=0.
REQ-023 SHALL drop WEN and REN asserted while BUSY=1: no array change and no RVALID.
REQ-024 SHALL implement clear FSM states CLEAR and READY; from CLEAR, a word counter writes zero to all lanes of words 0..DEPTH-1, one word per cycle, where DEPTH = 1<<(WIDTH_AD-WIDTH_DSB).
REQ-025 SHALL move from CLEAR to READY in the cycle after the counter writes word DEPTH-1; BUSY = (state==CLEAR).
REQ-026 SHALL, with CLEAR_ON_RESET=0, enter READY directly after reset and never enter CLEAR.

Reset
REQ-027 SHALL, while RESET=1, set RDATA=0, RVALID=0, clear all read-pipeline valid bits, zero the clear counter and set state to CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0).
REQ-028 SHALL hold BUSY=1 for exactly DEPTH cycles after RESET falls when CLEAR_ON_RESET=1.
REQ-029 SHALL restart the clear from word 0 when RESET is asserted mid-clear, and SHALL drop in-flight reads (no RVALID) when RESET is asserted mid-read.
REQ-030 SHALL leave array contents unchanged by reset itself; only the clear engine modifies them.

Structure
REQ-031 SHALL put the clog2 function, the legal RD_LAT values and the clear-FSM state encodings in the shared package mem_axi_dpram_pkg.
REQ-032 SHALL instantiate one sub-module per byte lane, mem_axi_dpram_pipe_lane: an 8-bit simple dual-port array with a write port and an unregistered-address synchronous read port.
REQ-033 SHALL keep the collision merge, the read pipeline, RVALID and the clear FSM in the top level.

Verification
REQ-034 SHALL test: WIDTH_DA=32, CLEAR_ON_RESET=1, then RESET pulse -> BUSY high 256 cycles; reads of words 0 and 255 return 0x00000000.
REQ-035 SHALL test: write 0xDEADBEEF to 0x010 with WSTRB=0xF, then read 0x010 with RSTRB=0x3 -> RDATA=0x0000BEEF after RD_LAT cycles, one RVALID pulse.
REQ-036 SHALL test: word 0x020 holds 0x11223344; same cycle write 0xAABBCCDD with WSTRB=0x5 and read 0x020 with RSTRB=0xF -> 0x11BB33DD.
REQ-037 SHALL test: RD_LAT=2, read 0x030 (holding 0x0), write 0xFFFFFFFF to 0x030 next cycle -> RDATA=0x00000000.
REQ-038 SHALL test: RESET asserted at clear word 100 -> clear restarts at 0 and BUSY lasts the full 256 cycles; a REN issued while BUSY produces no RVALID.
REQ-039 SHALL test: REN high for 8 consecutive cycles at addresses 0..28 step 4 -> 8 consecutive RVALID pulses with data in address order.
